// File: rtl/sprite_pkg.sv
// Shared sizes, drawer states and the pattern-ROM address helper for the sprite row drawer.
package sprite_pkg;
    localparam int SPR_W    = 16;
    localparam int SCREEN_W = 640;
    localparam int PIX_W    = 8;

    localparam logic [PIX_W-1:0] TRANSPARENT_IDX = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } draw_state_t;

    function automatic logic [15:0] make_rom_addr(input logic [7:0] frame,
                                                  input logic [3:0] row,
                                                  input logic [3:0] px);
        return {frame, row, px};
    endfunction
endpackage

// File: rtl/sprite_row_drawer_if.sv
// Draw-request, pattern-ROM and line-buffer signals between the sprite front-end/memories and the drawer.
interface sprite_row_drawer_if;
    logic                         start_row;
    logic                         draw_req;
    logic [9:0]                   col_base;
    logic                         flip;
    logic [7:0]                   frame_id;
    logic [3:0]                   row_off;
    logic                         draw_done;
    logic [15:0]                  rom_addr;
    logic [sprite_pkg::PIX_W-1:0] rom_data;
    logic                         lb_we;
    logic [9:0]                   lb_addr;
    logic [sprite_pkg::PIX_W-1:0] lb_wdata;

    modport master (
        output start_row, draw_req, col_base, flip, frame_id, row_off, rom_data,
        input  draw_done, rom_addr, lb_we, lb_addr, lb_wdata
    );

    modport slave (
        input  start_row, draw_req, col_base, flip, frame_id, row_off, rom_data,
        output draw_done, rom_addr, lb_we, lb_addr, lb_wdata
    );
endinterface

// File: rtl/sprite_cover_map.sv
// Per-column coverage bitmap: cleared per scanline, tested and set by line-buffer writes.
// Hit is combinational on the current address; set takes effect next cycle.
module sprite_cover_map
    import sprite_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic [9:0] i_addr,
    input  logic       i_set,
    output logic       o_hit
);
    logic [SCREEN_W-1:0] r_map;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_map <= '0;
        end else if (i_set && (i_addr < 10'(SCREEN_W))) begin
            r_map[i_addr] <= 1'b1;
        end
    end

    assign o_hit = (i_addr < 10'(SCREEN_W)) ? r_map[i_addr] : 1'b0;
endmodule

// File: rtl/sprite_row_drawer.sv
// Renders one 16-pixel sprite row into the line buffer; busy a fixed 18 cycles per request, no queuing.
// SPRITE_PRIORITY_EN: earliest-drawn sprite wins overlapping columns via a per-scanline coverage map.
module sprite_row_drawer
    import sprite_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    sprite_row_drawer_if.slave bus
);
    draw_state_t r_state;
    draw_state_t w_next;

    logic [3:0]  r_cnt;
    logic [3:0]  r_wi;
    logic [9:0]  r_col;
    logic        r_flip;
    logic [7:0]  r_frame;
    logic [3:0]  r_row;
    logic        r_vld;

    logic [3:0]  w_px;
    logic [10:0] w_col;
    logic        w_base_we;
    logic        w_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.draw_req) w_next = FETCH;
            FETCH:   if (r_cnt == 4'(SPR_W - 1)) w_next = DRAIN;
            DRAIN:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (bus.start_row) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_wi    <= '0;
            r_col   <= '0;
            r_flip  <= 1'b0;
            r_frame <= '0;
            r_row   <= '0;
            r_vld   <= 1'b0;
        end else begin
            // r_wi trails r_cnt by one cycle to line up with the ROM read latency
            r_vld <= (r_state == FETCH) && !bus.start_row;
            r_wi  <= r_cnt;
            if ((r_state == IDLE) && bus.draw_req && !bus.start_row) begin
                r_col   <= bus.col_base;
                r_flip  <= bus.flip;
                r_frame <= bus.frame_id;
                r_row   <= bus.row_off;
                r_cnt   <= '0;
            end else if (r_state == FETCH) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign w_px         = r_flip ? (4'(SPR_W - 1) - r_cnt) : r_cnt;
    assign bus.rom_addr = make_rom_addr(r_frame, r_row, w_px);

    // 11-bit sum so sprites hanging past column 1023 clip instead of wrapping to the left edge
    assign w_col     = {1'b0, r_col} + {7'd0, r_wi};
    assign w_base_we = r_vld && (bus.rom_data != TRANSPARENT_IDX) && (w_col < 11'(SCREEN_W));

`ifdef SPRITE_PRIORITY_EN
    logic w_hit;

    sprite_cover_map u_cover (
        .clk     (clk),
        .reset   (reset),
        .i_clear (bus.start_row),
        .i_addr  (w_col[9:0]),
        .i_set   (w_we),
        .o_hit   (w_hit)
    );

    assign w_we = w_base_we && !w_hit;
`else
    assign w_we = w_base_we;
`endif

    assign bus.lb_we     = w_we;
    assign bus.lb_addr   = w_col[9:0];
    assign bus.lb_wdata  = bus.rom_data;
    assign bus.draw_done = (r_state == IDLE) && !bus.draw_req;
endmodule

// File: tb/tb_sprite_row_drawer.sv
// Directed bench for sprite_row_drawer: per-cycle capture of each request, checked against hand-derived values.
module tb_sprite_row_drawer;
    localparam int NREC = 22;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    int   rom_mode;

    sprite_row_drawer_if bus();

    sprite_row_drawer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        logic [3:0] px;
        px = a[3:0];
        case (rom_mode)
            0:       return 8'({4'd0, px} + 8'd1);
            1:       return px[0] ? 8'({4'd0, px} + 8'd1) : 8'd0;
            2:       return 8'd7;
            default: return 8'd9;
        endcase
    endfunction

    always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

    logic [7:0] lb [0:1023];
    always @(posedge clk) if (bus.lb_we === 1'b1) lb[bus.lb_addr] <= bus.lb_wdata;

    logic        rec_done [0:NREC-1];
    logic [15:0] rec_addr [0:NREC-1];
    logic        rec_we   [0:NREC-1];
    logic [9:0]  rec_la   [0:NREC-1];
    logic [7:0]  rec_wd   [0:NREC-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic new_line();
        @(posedge clk); #1 bus.start_row = 1'b1;
        @(posedge clk); #1 bus.start_row = 1'b0;
    endtask

    task automatic run_draw(input logic [9:0] col, input logic fl, input logic [7:0] fr,
                            input logic [3:0] row, input int req2_at, input int sr_at);
        for (int k = 0; k < NREC; k++) begin
            @(posedge clk); #1;
            bus.draw_req  = (k == 0) || (k == req2_at);
            bus.start_row = (k == sr_at);
            if (k == 0) begin
                bus.col_base = col;
                bus.flip     = fl;
                bus.frame_id = fr;
                bus.row_off  = row;
            end
            if (k == req2_at) begin
                bus.col_base = 10'd300;
                bus.frame_id = 8'hAA;
            end
            @(negedge clk);
            rec_done[k] = bus.draw_done;
            rec_addr[k] = bus.rom_addr;
            rec_we[k]   = bus.lb_we;
            rec_la[k]   = bus.lb_addr;
            rec_wd[k]   = bus.lb_wdata;
        end
    endtask

    function automatic int n_writes();
        int n = 0;
        for (int k = 0; k < NREC; k++) if (rec_we[k] === 1'b1) n++;
        return n;
    endfunction

    function automatic int n_busy();
        int n = 0;
        for (int k = 0; k < NREC; k++) if (rec_done[k] === 1'b0) n++;
        return n;
    endfunction

    initial begin
        n_chk = 0;
        n_err = 0;
        rom_mode = 0;
        reset = 1'b1;
        bus.start_row = 1'b0;
        bus.draw_req  = 1'b0;
        bus.col_base  = '0;
        bus.flip      = 1'b0;
        bus.frame_id  = '0;
        bus.row_off   = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_done", bus.draw_done, 1);
        chk("reset_we", bus.lb_we, 0);
        chk("reset_rom_addr", bus.rom_addr, 0);

        // basic draw
        new_line();
        rom_mode = 0;
        run_draw(10'd100, 1'b0, 8'h03, 4'd5, -1, -1);
        chk("basic_done_T", rec_done[0], 0);
        chk("basic_done_T17", rec_done[17], 0);
        chk("basic_done_T18", rec_done[18], 1);
        chk("basic_busy", n_busy(), 18);
        chk("basic_nwr", n_writes(), 16);
        for (int k = 1; k <= 16; k++) chk("basic_rom_addr", rec_addr[k], 32'h0350 + k - 1);
        for (int k = 2; k <= 17; k++) begin
            chk("basic_we", rec_we[k], 1);
            chk("basic_lb_addr", rec_la[k], 100 + k - 2);
            chk("basic_lb_wdata", rec_wd[k], k - 1);
        end

        // flip
        new_line();
        run_draw(10'd100, 1'b1, 8'h03, 4'd5, -1, -1);
        for (int k = 1; k <= 16; k++) chk("flip_rom_addr", rec_addr[k], 32'h035F - (k - 1));
        chk("flip_first_addr", rec_la[2], 100);
        chk("flip_first_data", rec_wd[2], 16);
        chk("flip_last_addr", rec_la[17], 115);
        chk("flip_last_data", rec_wd[17], 1);
        chk("flip_busy", n_busy(), 18);

        // transparency: even px read back as 0
        new_line();
        rom_mode = 1;
        run_draw(10'd100, 1'b0, 8'h03, 4'd5, -1, -1);
        chk("transp_nwr", n_writes(), 8);
        chk("transp_busy", n_busy(), 18);
        for (int k = 2; k <= 17; k++) chk("transp_we", rec_we[k], ((k - 2) % 2 == 1) ? 1 : 0);
        chk("transp_first_col", rec_la[3], 101);
        chk("transp_last_col", rec_la[17], 115);

        // right-edge clip
        new_line();
        rom_mode = 0;
        run_draw(10'd630, 1'b0, 8'h03, 4'd5, -1, -1);
        chk("clip630_nwr", n_writes(), 10);
        chk("clip630_busy", n_busy(), 18);
        chk("clip630_last_we", rec_we[11], 1);
        chk("clip630_last_col", rec_la[11], 639);
        chk("clip630_cut_we", rec_we[12], 0);
        new_line();
        run_draw(10'd1020, 1'b0, 8'h03, 4'd5, -1, -1);
        chk("clip1020_nwr", n_writes(), 0);
        chk("clip1020_busy", n_busy(), 18);

        // second request at T+5 ignored, start_row at T+8 aborts
        new_line();
        run_draw(10'd100, 1'b0, 8'h03, 4'd5, 5, 8);
        chk("abort_rom_addr_T6", rec_addr[6], 32'h0355);
        chk("abort_done_T8", rec_done[8], 0);
        chk("abort_done_T9", rec_done[9], 1);
        chk("abort_busy", n_busy(), 9);
        chk("abort_nwr", n_writes(), 7);
        chk("abort_last_col", rec_la[8], 106);
        for (int k = 9; k < NREC; k++) chk("abort_no_we", rec_we[k], 0);

        // overlap: A at 200 (data 7), then B at 208 (data 9)
        new_line();
        rom_mode = 2;
        run_draw(10'd200, 1'b0, 8'h01, 4'd0, -1, -1);
        rom_mode = 3;
        run_draw(10'd208, 1'b0, 8'h02, 4'd0, -1, -1);
        chk("ovl_200", lb[200], 7);
        chk("ovl_207", lb[207], 7);
        for (int c = 208; c <= 215; c++) begin
`ifdef SPRITE_PRIORITY_EN
            chk("ovl_shared", lb[c], 7);
`else
            chk("ovl_shared", lb[c], 9);
`endif
        end
        for (int c = 216; c <= 223; c++) chk("ovl_b_only", lb[c], 9);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
